skolem_sweep_checker: RTL and testbench
=======================================

SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 SHALL have parameter N_IN, default 8, width of the Skolem candidate's input vector.
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0; 1 = end the sweep at the first failing vector.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse to begin a sweep; ignored unless state is IDLE or DONE.
REQ-006 SHALL have port abort  in  1  terminates the sweep from any state except IDLE.
REQ-007 SHALL have port vec_o  out  N_IN  input vector driven to the combinational Skolem candidate (bit k = input ik).
REQ-008 SHALL have port sk_i  in  1  candidate output for vec_o, valid in the same cycle.
REQ-009 SHALL have port chk_vec_o  out  N_IN  registered vector presented to the specification-formula evaluator.
REQ-010 SHALL have port chk_sk_o  out  1  registered candidate output paired with chk_vec_o.
REQ-011 SHALL have port ok_i  in  1  formula value for (chk_vec_o, chk_sk_o), combinational, valid in the same cycle.
REQ-012 SHALL have port busy  out  1  high in SWEEP and DRAIN.
REQ-013 SHALL have port done  out  1  high in DONE.
REQ-014 SHALL have port pass  out  1  in DONE: fail_cnt==0 and no abort occurred.
REQ-015 SHALL have port fail_cnt  out  N_IN+1  saturating count of failing vectors.
REQ-016 SHALL have port first_fail_vld  out  1  first_fail holds a captured vector.
REQ-017 SHALL have port first_fail  out  N_IN  lowest-numbered failing vector.

Function
REQ-018 SHALL implement states IDLE, SWEEP, DRAIN, DONE.
REQ-019 IDLE/DONE + start -> SWEEP; vec counter := 0; fail_cnt, first_fail_vld, pass and the abort flag cleared.
REQ-020 In SWEEP, vec_o SHALL equal the counter, which increments by 1 each cycle, from 0 to 2^N_IN-1 with no gaps.
REQ-021 Stage 1 SHALL register (vec_o, sk_i) into (chk_vec_o, chk_sk_o) with a stage-valid bit, giving a 1-cycle latency from vec_o to check.
REQ-022 A vector SHALL fail when the stage-valid bit is 1 and ok_i is 0; only valid cycles count.
REQ-023 On each failure fail_cnt SHALL increment and saturate at 2^N_IN; first_fail SHALL be captured only when first_fail_vld is 0.
REQ-024 After vector 2^N_IN-1 is issued, the block SHALL move SWEEP -> DRAIN (no counter wrap to 0), check the last vector, then DRAIN -> DONE.
REQ-025 With STOP_ON_FAIL=1, the first failure SHALL force DONE on the next cycle; an in-flight vector SHALL be discarded.
REQ-026 abort in SWEEP or DRAIN SHALL force DONE next cycle with pass=0 and results frozen; abort in DONE SHALL be ignored.
REQ-027 start and abort in the same cycle: abort SHALL win in SWEEP/DRAIN; start SHALL win in DONE.
REQ-028 A start pulse during SWEEP or DRAIN SHALL be ignored.
REQ-029 Results SHALL hold in DONE until the next start.
REQ-030 A full sweep SHALL take exactly 2^N_IN+1 cycles from the start cycle to done rising.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counter 0, vec_o 0, chk_vec_o 0, chk_sk_o 0, stage-valid 0, busy 0, done 0, pass 0, fail_cnt 0, first_fail_vld 0, first_fail 0.
REQ-032 Reset mid-sweep SHALL discard all progress; no partial result remains.

Structure
REQ-033 The state enum and the N_IN default SHALL live in a shared package, skolem_chk_pkg.
REQ-034 The vector counter plus the stage-1 register SHALL be one sub-module, skolem_vec_gen; the FSM and result logic stay in the top level.

Verification
REQ-035 N_IN=8, ok_i tied 1, start -> done after 257 cycles, pass=1, fail_cnt=0, vec_o swept 0x00..0xFF in order.
REQ-036 ok_i=0 only when chk_vec_o==0x2A or 0x91 -> fail_cnt=2, first_fail=0x2A, pass=0.
REQ-037 STOP_ON_FAIL=1, failure at vector 0x05 -> done within 2 cycles of the check, fail_cnt=1, first_fail=0x05.
REQ-038 abort at vector 0x40 -> DONE next cycle, pass=0, fail_cnt frozen; a following start runs a full clean sweep.
REQ-039 rst_n pulsed low at vector 0x80 -> all outputs 0 immediately, state IDLE, no done pulse.
REQ-040 ok_i tied 0 -> fail_cnt=256 (no overflow), first_fail=0x00.

Source files
------------

// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem sweep checker: FSM states and default vector width.
package skolem_chk_pkg;

    localparam int N_IN_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

endpackage

// File: rtl/skolem_vec_gen.sv
// Exhaustive input-vector generator plus the one-stage register that pairs each
// vector with the candidate output sampled for it.
module skolem_vec_gen
    import skolem_chk_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            adv_i,
    input  logic            sk_i,
    output logic [N_IN-1:0] vec_o,
    output logic            last_o,
    output logic [N_IN-1:0] chk_vec_o,
    output logic            chk_sk_o,
    output logic            chk_vld_o
);

    localparam logic [N_IN-1:0] VEC_MAX = '1;

    logic [N_IN-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0] chk_vec_q, chk_vec_d;
    logic            chk_sk_q, chk_sk_d;
    logic            chk_vld_q, chk_vld_d;

    assign vec_o     = cnt_q;
    assign last_o    = (cnt_q == VEC_MAX);
    assign chk_vec_o = chk_vec_q;
    assign chk_sk_o  = chk_sk_q;
    assign chk_vld_o = chk_vld_q;

    // Counter holds at the top vector instead of wrapping; the FSM leaves SWEEP there.
    always_comb begin
        cnt_d     = cnt_q;
        chk_vec_d = chk_vec_q;
        chk_sk_d  = chk_sk_q;
        chk_vld_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            if (cnt_q != VEC_MAX) begin
                cnt_d = cnt_q + N_IN'(1);
            end
            chk_vec_d = cnt_q;
            chk_sk_d  = sk_i;
            chk_vld_d = 1'b1;
        end
    end

    // Counter and check-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            chk_vec_q <= '0;
            chk_sk_q  <= 1'b0;
            chk_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            chk_vec_q <= chk_vec_d;
            chk_sk_q  <= chk_sk_d;
            chk_vld_q <= chk_vld_d;
        end
    end

endmodule

// File: rtl/skolem_sweep_checker.sv
// Sweeps every input vector through a combinational Skolem candidate and checks
// each (vector, candidate output) pair against the specification formula.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | out of reset, waiting for start
//   ST_SWEEP | issuing vectors 0 .. 2^N_IN-1, checking the previous one
//   ST_DRAIN | last vector issued, checking it
//   ST_DONE  | results held until the next start
module skolem_sweep_checker
    import skolem_chk_pkg::*;
#(
    parameter int N_IN         = N_IN_DEFAULT,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_o,
    input  logic            sk_i,
    output logic [N_IN-1:0] chk_vec_o,
    output logic            chk_sk_o,
    input  logic            ok_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic            first_fail_vld,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN:0] FAIL_MAX = {1'b1, {N_IN{1'b0}}};

    chk_state_e      state_q, state_d;
    logic            adv;
    logic            active;
    logic            start_go;
    logic            fail_chk;
    logic            last;
    logic            chk_vld;
    logic [N_IN-1:0] chk_vec;
    logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
    logic            ff_vld_q, ff_vld_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            aborted_q, aborted_d;

    skolem_vec_gen #(.N_IN(N_IN)) u_vec_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (start_go),
        .adv_i     (adv),
        .sk_i      (sk_i),
        .vec_o     (vec_o),
        .last_o    (last),
        .chk_vec_o (chk_vec),
        .chk_sk_o  (chk_sk_o),
        .chk_vld_o (chk_vld)
    );

    assign chk_vec_o = chk_vec;
    assign active    = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign start_go  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // A failure seen in the same cycle as abort is not counted: results freeze at abort.
    assign fail_chk  = active && chk_vld && !ok_i && !abort;

    assign busy           = active;
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (fail_cnt_q == '0) && !aborted_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail     = ff_q;

    // Next-state logic; adv is only raised when the issued vector will really be checked.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (STOP_ON_FAIL && fail_chk) begin
                    state_d = ST_DONE;
                end else begin
                    adv = 1'b1;
                    if (last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_d = ST_SWEEP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result bookkeeping: cleared on an accepted start, updated by valid checks.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        ff_vld_d   = ff_vld_q;
        ff_d       = ff_q;
        aborted_d  = aborted_q;
        if (start_go) begin
            fail_cnt_d = '0;
            ff_vld_d   = 1'b0;
            ff_d       = '0;
            aborted_d  = 1'b0;
        end else begin
            if (active && abort) aborted_d = 1'b1;
            if (fail_chk) begin
                if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + (N_IN+1)'(1);
                if (!ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_d     = chk_vec;
                end
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fail_cnt_q <= '0;
            ff_vld_q   <= 1'b0;
            ff_q       <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
            ff_vld_q   <= ff_vld_d;
            ff_q       <= ff_d;
            aborted_q  <= aborted_d;
        end
    end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Bench for skolem_sweep_checker: a random "true" Skolem function and a candidate
// that differs from it on chosen vectors; expected results come from a plain loop
// over all vectors and are checked by a monitor when done rises.
module tb_skolem_sweep_checker;

    localparam int N  = 8;
    localparam int NV = 1 << N;

    typedef struct {
        int sel;
        bit pass;
        int fcnt;
        bit ffv;
        int ff;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_r [2];
    logic          abort_r [2];
    logic          sk_w    [2];
    logic          ok_w    [2];
    logic [N-1:0]  vec_w   [2];
    logic [N-1:0]  chkv_w  [2];
    logic          chks_w  [2];
    logic          busy_w  [2];
    logic          done_w  [2];
    logic          pass_w  [2];
    logic [N:0]    fcnt_w  [2];
    logic          ffv_w   [2];
    logic [N-1:0]  ff_w    [2];

    logic [NV-1:0] refm;
    logic [NV-1:0] cand;
    logic          force0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc [2];
    int   exp_vec   [2];
    bit   prev_done [2];
    exp_t exp_q [$];

    assign sk_w[0] = cand[vec_w[0]];
    assign sk_w[1] = cand[vec_w[1]];
    assign ok_w[0] = !force0 && (chks_w[0] == refm[chkv_w[0]]);
    assign ok_w[1] = !force0 && (chks_w[1] == refm[chkv_w[1]]);

    skolem_sweep_checker #(.N_IN(N), .STOP_ON_FAIL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]),
        .vec_o(vec_w[0]), .sk_i(sk_w[0]), .chk_vec_o(chkv_w[0]), .chk_sk_o(chks_w[0]),
        .ok_i(ok_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_cnt(fcnt_w[0]), .first_fail_vld(ffv_w[0]), .first_fail(ff_w[0])
    );

    skolem_sweep_checker #(.N_IN(N), .STOP_ON_FAIL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]),
        .vec_o(vec_w[1]), .sk_i(sk_w[1]), .chk_vec_o(chkv_w[1]), .chk_sk_o(chks_w[1]),
        .ok_i(ok_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_cnt(fcnt_w[1]), .first_fail_vld(ffv_w[1]), .first_fail(ff_w[1])
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Expected outcome of one sweep, straight from the rules: walk all vectors in order.
    function automatic exp_t model(input int sel, input bit sof, input int abort_at);
        exp_t e;
        int   limit;
        e.sel  = sel;
        e.pass = 1'b0;
        e.fcnt = 0;
        e.ffv  = 1'b0;
        e.ff   = 0;
        e.lat  = NV + 1;
        limit  = (abort_at >= 0) ? abort_at - 1 : NV;
        for (int v = 0; v < limit; v++) begin
            if (force0 || (cand[v] != refm[v])) begin
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ff  = v;
                end
                e.fcnt++;
                if (sof) begin
                    e.lat = v + 2;
                    break;
                end
            end
        end
        if (abort_at >= 0) e.lat = abort_at + 1;
        e.pass = (abort_at < 0) && (e.fcnt == 0);
        return e;
    endfunction

    task automatic rand_maps(input bit flip);
        for (int i = 0; i < NV; i++) begin
            refm[i] = 1'($urandom_range(0, 1));
            cand[i] = refm[i] ^ (flip && ($urandom_range(0, 31) == 0));
        end
    endtask

    // Called at a negedge: drive for one active edge, then release 1 ns after it.
    task automatic drive(input int sel, input bit s, input bit a, input bit rec);
        start_r[sel] = s;
        abort_r[sel] = a;
        @(posedge clk);
        #1;
        if (rec) begin
            start_cyc[sel] = cyc;
            exp_vec[sel]   = 0;
        end
        start_r[sel] = 1'b0;
        abort_r[sel] = 1'b0;
    endtask

    task automatic wait_vec(input int sel, input int v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (busy_w[sel] && (int'(vec_w[sel]) == v)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_vec: vector 0x%0h never reached on dut%0d", v, sel);
        end
    endtask

    task automatic wait_empty();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 700 && !empty; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) empty = 1'b1;
        end
        if (!empty) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d expected results never delivered", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input int sel, input bit sof, input int abort_at, input bit start_at_abort,
                       input int ignored_start_at, input bit start_with_abort);
        exp_t e;
        e = model(sel, sof, abort_at);
        exp_q.push_back(e);
        @(negedge clk);
        drive(sel, 1'b1, start_with_abort, 1'b1);
        if (ignored_start_at >= 0) begin
            wait_vec(sel, ignored_start_at);
            drive(sel, 1'b1, 1'b0, 1'b0);
        end
        if (abort_at >= 0) begin
            wait_vec(sel, abort_at);
            drive(sel, start_at_abort, 1'b1, 1'b0);
        end
        wait_empty();
    endtask

    task automatic check_zero(input int s);
        chk("rst_vec_o",    int'(vec_w[s]),  0);
        chk("rst_chk_vec",  int'(chkv_w[s]), 0);
        chk("rst_chk_sk",   int'(chks_w[s]), 0);
        chk("rst_busy",     int'(busy_w[s]), 0);
        chk("rst_done",     int'(done_w[s]), 0);
        chk("rst_pass",     int'(pass_w[s]), 0);
        chk("rst_fail_cnt", int'(fcnt_w[s]), 0);
        chk("rst_ff_vld",   int'(ffv_w[s]),  0);
        chk("rst_ff",       int'(ff_w[s]),   0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: vector order while busy, and result/latency check on each rising done.
    initial begin
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (busy_w[s] && exp_vec[s] < NV) begin
                    chk("vec_order", int'(vec_w[s]), exp_vec[s]);
                    exp_vec[s]++;
                end
                if (done_w[s] && !prev_done[s]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", exp_q.size(), 1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("done_instance", s, e.sel);
                        chk("pass", int'(pass_w[s]), int'(e.pass));
                        chk("fail_cnt", int'(fcnt_w[s]), e.fcnt);
                        chk("first_fail_vld", int'(ffv_w[s]), int'(e.ffv));
                        if (e.ffv) chk("first_fail", int'(ff_w[s]), e.ff);
                        chk("latency", cyc - start_cyc[s], e.lat);
                    end
                end
                prev_done[s] = done_w[s];
            end
        end
    end

    initial begin
        exp_t hold_e;
        rst_n      = 1'b0;
        start_r    = '{1'b0, 1'b0};
        abort_r    = '{1'b0, 1'b0};
        force0     = 1'b0;
        refm       = '0;
        cand       = '0;
        exp_vec    = '{NV, NV};
        start_cyc  = '{0, 0};
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;

        // clean sweep
        rand_maps(1'b0);
        run(0, 1'b0, -1, 1'b0, -1, 1'b0);

        // two known failures, plus a start pulse mid-sweep that must be ignored
        cand = refm;
        cand[8'h2A] = ~refm[8'h2A];
        cand[8'h91] = ~refm[8'h91];
        run(0, 1'b0, -1, 1'b0, 8'h10, 1'b0);

        // random sparse failures
        rand_maps(1'b1);
        run(0, 1'b0, -1, 1'b0, -1, 1'b0);

        // abort at vector 0x40, then abort in DONE is ignored and results hold
        rand_maps(1'b1);
        cand[8'h3F] = refm[8'h3F];
        hold_e = model(0, 1'b0, 8'h40);
        run(0, 1'b0, 8'h40, 1'b0, -1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("hold_done", int'(done_w[0]), 1);
        chk("hold_pass", int'(pass_w[0]), 0);
        chk("hold_fail_cnt", int'(fcnt_w[0]), hold_e.fcnt);

        // clean sweep after the abort
        cand = refm;
        run(0, 1'b0, -1, 1'b0, -1, 1'b0);

        // start+abort together in DONE: start wins; every vector fails
        force0 = 1'b1;
        run(0, 1'b0, -1, 1'b0, -1, 1'b1);
        force0 = 1'b0;

        // start+abort together in SWEEP: abort wins
        rand_maps(1'b1);
        cand[8'h1F] = refm[8'h1F];
        run(0, 1'b0, 8'h20, 1'b1, -1, 1'b0);

        // stop-on-fail instance: failure at 0x05, random, clean
        cand = refm;
        cand[8'h05] = ~refm[8'h05];
        run(1, 1'b1, -1, 1'b0, -1, 1'b0);
        rand_maps(1'b1);
        run(1, 1'b1, -1, 1'b0, -1, 1'b0);
        cand = refm;
        run(1, 1'b1, -1, 1'b0, -1, 1'b0);

        // reset in the middle of a sweep at vector 0x80
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b1);
        wait_vec(0, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0);
        check_zero(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_done", int'(done_w[0]), 0);
        chk("post_rst_busy", int'(busy_w[0]), 0);

        // recovery sweep
        run(0, 1'b0, -1, 1'b0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
